engine_top_core: RTL and testbench
==================================

ENGINE_TOP_CORE -- requirements
Module: engine_top

Interface
REQ-001 K_MAX, default 4: maximum data columns; number of bit-matrix registers.
REQ-002 K_MIN, default 2: minimum data columns; XOR-unit stride.
REQ-003 W, default 4: GF(2^W) word width, in packets per word.
REQ-004 PACKET_LENGTH, default 2: bits per packet.
REQ-005 BM_MULT_UNIT_NUM, default 4: bit-matrix multiply units (BMUs).
REQ-006 Derived localparams: PCK_TREE_XOR_UNITS_NUM=BM_MULT_UNIT_NUM/K_MIN; BMU_BM_MUX_SEL_W=$clog2(K_MAX).
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rstn  in  1  asynchronous active-low reset.
REQ-009 eng_rstn  in  1  synchronous active-low pipeline flush.
REQ-010 bmu_bm_mux_sel_reg_wr  in  1  load the per-BMU matrix selects.
REQ-011 bmu_bm_mux_sel_reg_din  in  [BMU_BM_MUX_SEL_W-1:0] x BM_MULT_UNIT_NUM  matrix index per BMU.
REQ-012 and_mask_mask_reg_wr  in  1  load the XOR-unit masks.
REQ-013 and_mask_mask_reg_din  in  [0:K_MAX-1] x PCK_TREE_XOR_UNITS_NUM  per-unit input enables.
REQ-014 inbuf_eng_din_reg  in  [PACKET_LENGTH-1:0] x BM_MULT_UNIT_NUM x W  data words, one per BMU.
REQ-015 inbuf_eng_din_reg_val  in  1  data valid.
REQ-016 cntl_eng_bm_col_din_reg  in  [W-1:0] x K_MAX x W  bit matrices [k][row].
REQ-017 cntl_eng_bm_col_din_reg_val  in  1  bit matrices valid.
REQ-018 cntrl_eng_calc_en  in  1  enables input acceptance.
REQ-019 global_reg_wr_en  in  1  enables bit-matrix register writes.
REQ-020 outbuf_eng_wr_ack  in  1  output buffer accepts the result.
REQ-021 outbuf_eng_full  in  1  output buffer full.
REQ-022 data_used  out  1  input word consumed this cycle.
REQ-023 eng_pl_empty  out  1  no valid data in any pipeline stage.
REQ-024 eng_outbuf_dout_reg  out  [PACKET_LENGTH-1:0] x PCK_TREE_XOR_UNITS_NUM x W  parity words.
REQ-025 eng_outbuf_wr_req  out  1  result valid, write requested.

Function
REQ-026 Bit-matrix regs load on a clock edge when cntl_eng_bm_col_din_reg_val & global_reg_wr_en; select and mask regs load when their _wr input is high.
REQ-027 Stage 0 accept: stage 0 captures inbuf_eng_din_reg when inbuf_eng_din_reg_val & cntrl_eng_calc_en & stage0_ready; data_used=1 combinationally in that cycle only.
REQ-028 BMU b uses matrix M=bm[sel[b]]; output packet i = XOR of data[b][j] over all j with M[i] bit j = 1 (bit 0 = LSB).
REQ-029 XOR unit u, output packet i = XOR over n in 0..K_MAX-1 of BMU(u*K_MIN+n) packet i, gated by mask[u][n]; BMU indices >= BM_MULT_UNIT_NUM contribute zero.
REQ-030 Pipeline: stage 0 input reg, stage 1 BMU reg, stage 2 output reg; latency 3 edges from accept to eng_outbuf_wr_req.
REQ-031 eng_outbuf_wr_req = out_valid & ~outbuf_eng_full; a transfer occurs only when wr_req & wr_ack are high in the same cycle.
REQ-032 Output data holds stable until transferred; a stage advances when the next stage is empty or draining in the same cycle; full throughput is one word per cycle.
REQ-033 Simultaneous accept and transfer is legal with no bubble; full with stage 2 occupied stalls the whole pipeline back to data_used=0.
REQ-034 Config registers change only between words; a change takes effect on the next stage-1 or stage-2 computation.
REQ-035 eng_pl_empty = ~(v0|v1|v2).

Reset
REQ-036 rstn low: all valid bits, config registers and output data clear to 0 asynchronously; eng_outbuf_wr_req=0, data_used=0, eng_pl_empty=1.
REQ-037 eng_rstn low at an edge: valid bits clear and config is kept; this applies mid-operation, and in-flight words are dropped.

Configuration
REQ-038 With macro ENGINE_BMU_PIPE_REG_EN defined, the stage-1 register exists and latency is 3; when it is undefined, the BMU feeds the XOR units combinationally and latency is 2; function is identical in both builds.

Verification
REQ-039 Reset, then no stimulus -> eng_pl_empty=1, wr_req=0, dout all 0.
REQ-040 bm[0] rows {1101,0011,0101,1100}, sel0=0, mask0 index0 only, BMU0 data {11,11,01,00} -> unit0 dout {10,00,10,01} after the latency.
REQ-041 Identity matrices, mask0 indices 0,1, data BMU0={01,..} and BMU1={11,..} -> unit0 packet0=10.
REQ-042 outbuf_eng_full=1 with continuous valid input -> wr_req=0, pipeline fills, data_used drops to 0, and no word is lost after full clears.
REQ-043 Back-to-back words with wr_ack held at 1 -> one result per cycle, in order.
REQ-044 eng_rstn pulse mid-stream -> eng_pl_empty=1 next cycle and the matrices are retained.

Source files
------------

// File: rtl/engine_top_core_if.sv
// engine_top_core_if: configuration, input-word and output-word signals of the
// erasure-coding engine. The master side drives configuration and data, the
// slave side (the engine) returns the parity words and handshake status.
interface engine_top_core_if #(
  parameter int K_MAX            = 4,
  parameter int K_MIN            = 2,
  parameter int W                = 4,
  parameter int PACKET_LENGTH    = 2,
  parameter int BM_MULT_UNIT_NUM = 4
);
  localparam int PCK_TREE_XOR_UNITS_NUM = BM_MULT_UNIT_NUM / K_MIN;
  localparam int BMU_BM_MUX_SEL_W       = $clog2(K_MAX);

  // Configuration
  logic                                                  bmu_bm_mux_sel_reg_wr;
  logic [BM_MULT_UNIT_NUM-1:0][BMU_BM_MUX_SEL_W-1:0]     bmu_bm_mux_sel_reg_din;
  logic                                                  and_mask_mask_reg_wr;
  logic [PCK_TREE_XOR_UNITS_NUM-1:0][K_MAX-1:0]          and_mask_mask_reg_din;  // bit n = input n
  logic [K_MAX-1:0][W-1:0][W-1:0]                        cntl_eng_bm_col_din_reg; // [k][row][bit]
  logic                                                  cntl_eng_bm_col_din_reg_val;
  logic                                                  global_reg_wr_en;

  // Input words
  logic [BM_MULT_UNIT_NUM-1:0][W-1:0][PACKET_LENGTH-1:0] inbuf_eng_din_reg;       // [bmu][packet]
  logic                                                  inbuf_eng_din_reg_val;
  logic                                                  cntrl_eng_calc_en;
  logic                                                  data_used;
  logic                                                  eng_pl_empty;

  // Output words
  logic [PCK_TREE_XOR_UNITS_NUM-1:0][W-1:0][PACKET_LENGTH-1:0] eng_outbuf_dout_reg; // [unit][packet]
  logic                                                  eng_outbuf_wr_req;
  logic                                                  outbuf_eng_wr_ack;
  logic                                                  outbuf_eng_full;

  modport master (
    output bmu_bm_mux_sel_reg_wr, bmu_bm_mux_sel_reg_din, and_mask_mask_reg_wr,
           and_mask_mask_reg_din, cntl_eng_bm_col_din_reg, cntl_eng_bm_col_din_reg_val,
           global_reg_wr_en, inbuf_eng_din_reg, inbuf_eng_din_reg_val, cntrl_eng_calc_en,
           outbuf_eng_wr_ack, outbuf_eng_full,
    input  data_used, eng_pl_empty, eng_outbuf_dout_reg, eng_outbuf_wr_req
  );

  modport slave (
    input  bmu_bm_mux_sel_reg_wr, bmu_bm_mux_sel_reg_din, and_mask_mask_reg_wr,
           and_mask_mask_reg_din, cntl_eng_bm_col_din_reg, cntl_eng_bm_col_din_reg_val,
           global_reg_wr_en, inbuf_eng_din_reg, inbuf_eng_din_reg_val, cntrl_eng_calc_en,
           outbuf_eng_wr_ack, outbuf_eng_full,
    output data_used, eng_pl_empty, eng_outbuf_dout_reg, eng_outbuf_wr_req
  );
endinterface

// File: rtl/engine_top_core.sv
// engine_top_core: GF(2^W) bit-matrix parity engine. Each BMU multiplies its
// data word by a selectable bit matrix; XOR units combine K_MAX neighbouring
// BMU outputs (stride K_MIN) under a per-unit mask. Valid/ready pipeline with
// input, optional BMU, and output stages.
// Build option: define ENGINE_BMU_PIPE_REG_EN to add the BMU register stage
// (latency 3); by default the BMU feeds the XOR units directly (latency 2).
module engine_top_core #(
  parameter int K_MAX            = 4,
  parameter int K_MIN            = 2,
  parameter int W                = 4,
  parameter int PACKET_LENGTH    = 2,
  parameter int BM_MULT_UNIT_NUM = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               eng_rstn,
  engine_top_core_if.slave   bus
);
  localparam int PCK_TREE_XOR_UNITS_NUM = BM_MULT_UNIT_NUM / K_MIN;
  localparam int BMU_BM_MUX_SEL_W       = $clog2(K_MAX);
  // Zero-padded BMU span so every unit can address K_MAX inputs.
  localparam int EXT_NUM = (PCK_TREE_XOR_UNITS_NUM - 1) * K_MIN + K_MAX;

  typedef logic [BM_MULT_UNIT_NUM-1:0][W-1:0][PACKET_LENGTH-1:0]       bmu_words_t;
  typedef logic [PCK_TREE_XOR_UNITS_NUM-1:0][W-1:0][PACKET_LENGTH-1:0] unit_words_t;
  typedef logic [K_MAX-1:0][W-1:0][W-1:0]                              bm_set_t;
  typedef logic [BM_MULT_UNIT_NUM-1:0][BMU_BM_MUX_SEL_W-1:0]           sel_set_t;
  typedef logic [PCK_TREE_XOR_UNITS_NUM-1:0][K_MAX-1:0]                mask_set_t;

  // Packet i of BMU b = XOR of data packets j whose bit j is set in row i.
  function automatic bmu_words_t bmu_mult(bmu_words_t d, bm_set_t bm, sel_set_t sel);
    bmu_words_t r;
    r = '0;
    for (int b = 0; b < BM_MULT_UNIT_NUM; b++)
      for (int i = 0; i < W; i++)
        for (int j = 0; j < W; j++)
          if (bm[sel[b]][i][j]) r[b][i] = r[b][i] ^ d[b][j];
    return r;
  endfunction

  // Unit u combines BMUs u*K_MIN .. u*K_MIN+K_MAX-1; missing BMUs read as zero.
  function automatic unit_words_t xor_tree(bmu_words_t m, mask_set_t mask);
    logic [EXT_NUM-1:0][W-1:0][PACKET_LENGTH-1:0] ext;
    unit_words_t r;
    ext = '0;
    r   = '0;
    for (int b = 0; b < BM_MULT_UNIT_NUM; b++) ext[b] = m[b];
    for (int u = 0; u < PCK_TREE_XOR_UNITS_NUM; u++)
      for (int n = 0; n < K_MAX; n++)
        if (mask[u][n]) r[u] = r[u] ^ ext[u*K_MIN+n];
    return r;
  endfunction

  bm_set_t     bm_q, bm_d;
  sel_set_t    sel_q, sel_d;
  mask_set_t   mask_q, mask_d;
  logic        v0_q, v0_d;
  bmu_words_t  d0_q, d0_d;
  logic        v2_q, v2_d;
  unit_words_t dout_q, dout_d;

  logic        wr_req, xfer, ready2, ready0, adv0, accept;
  logic        src2_v, stage1_busy;
  bmu_words_t  src2_bmu;

  assign wr_req = v2_q & ~bus.outbuf_eng_full;
  assign xfer   = wr_req & bus.outbuf_eng_wr_ack;
  assign ready2 = ~v2_q | xfer;
  assign ready0 = ~v0_q | adv0;
  // A word about to be flushed is not reported as consumed.
  assign accept = bus.inbuf_eng_din_reg_val & bus.cntrl_eng_calc_en & ready0 & eng_rstn & rstn;

`ifdef ENGINE_BMU_PIPE_REG_EN
  logic       v1_q, v1_d;
  bmu_words_t bmu_q, bmu_d;

  assign adv0        = ~v1_q | ready2;
  assign src2_v      = v1_q;
  assign src2_bmu    = bmu_q;
  assign stage1_busy = v1_q;

  // Stage 1: register the BMU products of the word leaving stage 0.
  always_comb begin
    v1_d  = v1_q;
    bmu_d = bmu_q;
    if (!eng_rstn) begin
      v1_d = 1'b0;
    end else if (adv0) begin
      v1_d = v0_q;
      if (v0_q) bmu_d = bmu_mult(d0_q, bm_q, sel_q);
    end
  end

  // Stage 1 state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q  <= 1'b0;
      bmu_q <= '0;
    end else begin
      v1_q  <= v1_d;
      bmu_q <= bmu_d;
    end
  end
`else
  assign adv0        = ready2;
  assign src2_v      = v0_q;
  assign src2_bmu    = bmu_mult(d0_q, bm_q, sel_q);
  assign stage1_busy = 1'b0;
`endif

  // Config loads, and stage 0 / stage 2 advance with flush on eng_rstn.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    bm_d   = bm_q;
    sel_d  = sel_q;
    mask_d = mask_q;
    v0_d   = v0_q;
    d0_d   = d0_q;
    v2_d   = v2_q;
    dout_d = dout_q;

    if (bus.cntl_eng_bm_col_din_reg_val && bus.global_reg_wr_en) bm_d = bus.cntl_eng_bm_col_din_reg;
    if (bus.bmu_bm_mux_sel_reg_wr) sel_d  = bus.bmu_bm_mux_sel_reg_din;
    if (bus.and_mask_mask_reg_wr)  mask_d = bus.and_mask_mask_reg_din;

    if (!eng_rstn) begin
      v0_d = 1'b0;
    end else if (accept) begin
      v0_d = 1'b1;
      d0_d = bus.inbuf_eng_din_reg;
    end else if (adv0) begin
      v0_d = 1'b0;
    end

    if (!eng_rstn) begin
      v2_d = 1'b0;
    end else if (ready2) begin
      v2_d = src2_v;
      if (src2_v) dout_d = xor_tree(src2_bmu, mask_q);
    end
  end

  // Config and pipeline state registers.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: config registers are reset as well, so a fresh engine never computes with X matrices.
    if (!rstn) begin
      bm_q   <= '0;
      sel_q  <= '0;
      mask_q <= '0;
      v0_q   <= 1'b0;
      d0_q   <= '0;
      v2_q   <= 1'b0;
      dout_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      bm_q   <= bm_d;
      sel_q  <= sel_d;
      mask_q <= mask_d;
      v0_q   <= v0_d;
      d0_q   <= d0_d;
      v2_q   <= v2_d;
      dout_q <= dout_d;
    end
  end

  assign bus.data_used           = accept;
  assign bus.eng_pl_empty        = ~(v0_q | stage1_busy | v2_q);
  assign bus.eng_outbuf_dout_reg = dout_q;
  assign bus.eng_outbuf_wr_req   = wr_req;
endmodule

// File: tb/tb_engine_top_core.sv
// tb_engine_top_core: directed vectors with a scoreboard. The driver pushes the
// hand-computed parity word when the engine consumes an input; a monitor pops
// and compares on every output transfer.
module tb_engine_top_core;
`ifdef ENGINE_BMU_PIPE_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  // bm[0] rows {1101,0011,0101,1100}; bm[1..3] identity.
  localparam logic [63:0] BM_A = {16'h8421, 16'h8421, 16'h8421, 16'hC53D};
  // BMU0 packets {11,11,01,00}; unit0 expected {10,00,10,01}.
  localparam logic [31:0] W040 = {8'h00, 8'h00, 8'h00, 8'b00_01_11_11};
  localparam logic [15:0] E040 = {8'h00, 8'b01_10_00_10};

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic eng_rstn = 1'b1;
  always #5 clk = ~clk;

  engine_top_core_if bus();
  engine_top_core dut (.clk(clk), .rstn(rstn), .eng_rstn(eng_rstn), .bus(bus));

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int xfer_cnt = 0;
  int first_xfer = 0;
  int last_xfer = 0;
  int stall_cnt = 0;
  logic [15:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every transferred word against the scoreboard head.
  always @(negedge clk) begin
    logic [15:0] exp_w;
    if (rstn && bus.eng_outbuf_wr_req && bus.outbuf_eng_wr_ack) begin
      if (sb_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_out: got %h with nothing expected", bus.eng_outbuf_dout_reg);
      end else begin
        exp_w = sb_q.pop_front();
        check("dout", 32'(bus.eng_outbuf_dout_reg), 32'(exp_w));
        if (xfer_cnt == 0) first_xfer = cyc;
        last_xfer = cyc;
        xfer_cnt++;
      end
    end
    if (rstn && bus.outbuf_eng_full) check("wr_req_while_full", 32'(bus.eng_outbuf_wr_req), 32'd0);
  end

  function automatic logic [31:0] mk_word(int i);
    logic [7:0] a, b;
    a = 8'(i * 37 + 5);
    b = 8'(i * 91 + 17);
    return {8'h3C, b, 8'hA5, a};
  endfunction

  // With identity matrices and mask n=0 per unit: unit0 = BMU0, unit1 = BMU2.
  function automatic logic [15:0] mk_exp(int i);
    logic [7:0] a, b;
    a = 8'(i * 37 + 5);
    b = 8'(i * 91 + 17);
    return {b, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [63:0] bm, input logic [7:0] sel, input logic [7:0] mask);
    bus.cntl_eng_bm_col_din_reg     = bm;
    bus.cntl_eng_bm_col_din_reg_val = 1'b1;
    bus.global_reg_wr_en            = 1'b1;
    bus.bmu_bm_mux_sel_reg_din      = sel;
    bus.bmu_bm_mux_sel_reg_wr       = 1'b1;
    bus.and_mask_mask_reg_din       = mask;
    bus.and_mask_mask_reg_wr        = 1'b1;
    tick();
    bus.cntl_eng_bm_col_din_reg_val = 1'b0;
    bus.bmu_bm_mux_sel_reg_wr       = 1'b0;
    bus.and_mask_mask_reg_wr        = 1'b0;
  endtask

  // Present one word until consumed; leaves valid high for back-to-back use.
  task automatic send(input logic [31:0] din, input logic [15:0] exp);
    bit got = 1'b0;
    bus.inbuf_eng_din_reg     = din;
    bus.inbuf_eng_din_reg_val = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus.data_used) begin
        sb_q.push_back(exp);
        got = 1'b1;
      end else begin
        stall_cnt++;
      end
      @(posedge clk);
      #1;
    end
    if (!got) begin
      total_cnt++;
      $display("FAIL send_timeout: word %h not accepted", din);
    end
  endtask

  task automatic drain();
    int k = 0;
    bus.inbuf_eng_din_reg_val = 1'b0;
    while (k < 50 && !(sb_q.size() == 0 && bus.eng_pl_empty)) begin
      tick();
      k++;
    end
    check("drain_done", {31'h0, (sb_q.size() == 0 && bus.eng_pl_empty)}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int idx;
    bit seen;
    bit used;

    bus.bmu_bm_mux_sel_reg_wr       = 1'b0;
    bus.bmu_bm_mux_sel_reg_din      = '0;
    bus.and_mask_mask_reg_wr        = 1'b0;
    bus.and_mask_mask_reg_din       = '0;
    bus.cntl_eng_bm_col_din_reg     = '0;
    bus.cntl_eng_bm_col_din_reg_val = 1'b0;
    bus.global_reg_wr_en            = 1'b0;
    bus.inbuf_eng_din_reg           = '0;
    bus.inbuf_eng_din_reg_val       = 1'b1;   // valid during reset must not be consumed
    bus.cntrl_eng_calc_en           = 1'b1;
    bus.outbuf_eng_wr_ack           = 1'b1;
    bus.outbuf_eng_full             = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data_used", 32'(bus.data_used), 32'd0);
    check("rst_empty", 32'(bus.eng_pl_empty), 32'd1);
    bus.inbuf_eng_din_reg_val = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    tick();
    check("idle_empty", 32'(bus.eng_pl_empty), 32'd1);
    check("idle_wr_req", 32'(bus.eng_outbuf_wr_req), 32'd0);
    check("idle_dout", 32'(bus.eng_outbuf_dout_reg), 32'd0);

    // Single bit-matrix product and accept-to-result latency
    set_cfg(BM_A, 8'b01_01_01_00, 8'b0000_0001);
    send(W040, E040);
    bus.inbuf_eng_din_reg_val = 1'b0;
    lat = 1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus.eng_outbuf_wr_req) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    check("latency", 32'(lat), 32'(LAT));
    drain();

    // Two BMUs through identity, XOR of packet 0: 01 ^ 11 = 10
    set_cfg(BM_A, 8'b01_01_01_01, 8'b0000_0011);
    send({8'h00, 8'h00, 8'b00_00_00_11, 8'b00_00_00_01}, 16'h0002);
    drain();

    // Unit1 all mask bits: inputs beyond the last BMU add nothing
    set_cfg(BM_A, 8'b01_01_01_01, 8'b1111_0001);
    send({8'hC9, 8'h36, 8'hFF, 8'h1B}, {8'hFF, 8'h1B});
    drain();

    // Back-to-back stream: one result per cycle, in order
    set_cfg(BM_A, 8'b01_01_01_01, 8'b0001_0001);
    xfer_cnt = 0;
    stall_cnt = 0;
    for (int i = 0; i < 8; i++) send(mk_word(i), mk_exp(i));
    drain();
    check("stream_count", 32'(xfer_cnt), 32'd8);
    check("stream_span", 32'(last_xfer - first_xfer), 32'd7);
    check("stream_stalls", 32'(stall_cnt), 32'd0);

    // Output full: pipeline fills then stalls; nothing lost once released
    bus.outbuf_eng_full = 1'b1;
    xfer_cnt = 0;
    idx = 0;
    used = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.inbuf_eng_din_reg     = mk_word(idx + 20);
      bus.inbuf_eng_din_reg_val = 1'b1;
      @(negedge clk);
      used = bus.data_used;
      if (used) begin
        sb_q.push_back(mk_exp(idx + 20));
        idx++;
      end
      @(posedge clk);
      #1;
    end
    check("full_fill", 32'(idx), 32'(LAT));
    check("full_stall_data_used", 32'(used), 32'd0);
    check("full_hold_dout", 32'(bus.eng_outbuf_dout_reg), 32'(sb_q[0]));
    bus.outbuf_eng_full = 1'b0;
    for (int c = 0; c < 40 && idx < 6; c++) begin
      bus.inbuf_eng_din_reg     = mk_word(idx + 20);
      bus.inbuf_eng_din_reg_val = 1'b1;
      @(negedge clk);
      if (bus.data_used) begin
        sb_q.push_back(mk_exp(idx + 20));
        idx++;
      end
      @(posedge clk);
      #1;
    end
    drain();
    check("full_all_out", 32'(xfer_cnt), 32'd6);

    // eng_rstn mid-stream: flush in-flight words, keep configuration
    set_cfg(BM_A, 8'b01_01_01_00, 8'b0000_0001);
    bus.outbuf_eng_wr_ack = 1'b0;
    send(W040, E040);
    send(mk_word(3), mk_exp(3));
    bus.inbuf_eng_din_reg_val = 1'b0;
    check("pre_flush_busy", 32'(bus.eng_pl_empty), 32'd0);
    eng_rstn = 1'b0;
    tick();
    eng_rstn = 1'b1;
    @(negedge clk);
    check("flush_empty", 32'(bus.eng_pl_empty), 32'd1);
    check("flush_wr_req", 32'(bus.eng_outbuf_wr_req), 32'd0);
    sb_q.delete();
    bus.outbuf_eng_wr_ack = 1'b1;
    // Matrix write with register writes disabled must be ignored
    bus.cntl_eng_bm_col_din_reg     = '0;
    bus.cntl_eng_bm_col_din_reg_val = 1'b1;
    bus.global_reg_wr_en            = 1'b0;
    tick();
    bus.cntl_eng_bm_col_din_reg_val = 1'b0;
    xfer_cnt = 0;
    send(W040, E040);
    drain();
    check("retained_out", 32'(xfer_cnt), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
